// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: request, response and multiplier signal bundle for booth_mul_arbiter
//   req0_* / req1_* : requester valid/ready handshakes carrying 32-bit two's complement operands
//   resp_*          : product return handshake with the id of the issuing requester
//   mul_x/mul_y/mul_p : operands to and product from the shared external Booth multiplier
//   busy            : block is occupied by an operation
interface booth_mul_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_id;
   logic [63:0] resp_p;
   logic [31:0] mul_x;
   logic [31:0] mul_y;
   logic [63:0] mul_p;
   logic        busy;
   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready, mul_p,
      output req0_ready, req1_ready, resp_valid, resp_id, resp_p, mul_x, mul_y, busy
   );
   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready, mul_p,
      input  req0_ready, req1_ready, resp_valid, resp_id, resp_p, mul_x, mul_y, busy
   );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one external 32x32 signed Booth multiplier between two requesters
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of booth_mul_arbiter_if (requester handshakes, response, multiplier operands/product, busy)
module booth_mul_arbiter #(
   parameter int MUL_LAT = 2
) (
   input logic               clk,
   input logic               rst,
   booth_mul_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t      state;
   state_t      nxt;
   logic        last_grant;
   logic        id;
   logic        grant;
   logic        idle;
   logic        rdy0;
   logic        rdy1;
   logic        take;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  cnt;
   logic [63:0] resp_p;
   logic        resp_id;
   logic        resp_valid;
   // On a tie the requester that did not win last time gets the multiplier
   assign grant = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
   // No acceptance while reset is asserted, even from IDLE
   assign idle = (state == IDLE) && !rst;
   assign rdy0 = idle && bus.req0_valid && !grant;
   assign rdy1 = idle && bus.req1_valid && grant;
   assign take = rdy0 || rdy1;
   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.mul_x = op_a;
   assign bus.mul_y = op_b;
   assign bus.resp_p = resp_p;
   assign bus.resp_id = resp_id;
   assign bus.resp_valid = resp_valid;
   assign bus.busy = state != IDLE;
   always_ff @(posedge clk)
      state <= rst ? IDLE : nxt;
   always_comb begin
      nxt = state;
      if (state == IDLE && take) nxt = WAIT;
      else if (state == WAIT && cnt == 4'd0) nxt = DONE;
      else if (state == DONE && bus.resp_ready) nxt = IDLE;
   end
   // Operands stay frozen through WAIT so the multicycle path through the multiplier settles
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         id <= 1'b0;
         op_a <= '0;
         op_b <= '0;
         cnt <= '0;
         resp_p <= '0;
         resp_id <= 1'b0;
         resp_valid <= 1'b0;
      end else begin
         if (take) begin
            op_a <= grant ? bus.req1_a : bus.req0_a;
            op_b <= grant ? bus.req1_b : bus.req0_b;
            id <= grant;
            last_grant <= grant;
            cnt <= 4'(MUL_LAT - 1);
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (state == WAIT && cnt == 4'd0) begin
            resp_p <= bus.mul_p;
            resp_id <= id;
            resp_valid <= 1'b1;
         end else if (state == DONE && bus.resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: randomized and directed self-checking bench for booth_mul_arbiter
module tb_booth_mul_arbiter;
   localparam int LAT = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int last_lat = 0;
   bit started = 1'b0;
   bit pend = 1'b0;
   int grant_q[$];
   logic [63:0] rp_q[$];
   logic rid_q[$];
   bit m_act, m_rv, m_rid, m_last, m_id;
   logic [31:0] m_x, m_y;
   logic [63:0] m_rp;
   int m_t;
   booth_mul_arbiter_if bus ();
   booth_mul_arbiter_if bus1 ();
   booth_mul_arbiter #(.MUL_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   booth_mul_arbiter #(.MUL_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   always #5 clk = ~clk;
   function automatic logic [63:0] prod(logic [31:0] a, logic [31:0] b);
      return 64'(longint'($signed(a)) * longint'($signed(b)));
   endfunction
   assign bus.mul_p = prod(bus.mul_x, bus.mul_y);
   assign bus1.mul_p = prod(bus1.mul_x, bus1.mul_y);
   function automatic bit win(bit v0, bit v1, bit last);
      return (v0 && v1) ? !last : v1;
   endfunction
   function automatic bit exp_ready(bit n);
      bit v;
      v = n ? bus.req1_valid : bus.req0_valid;
      return !rst && !m_act && v && (win(bus.req0_valid, bus.req1_valid, m_last) == n);
   endfunction
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h80000000;
         2: return 32'h7FFFFFFF;
         3: return 32'hFFFFFFFF;
         4: return 32'h1;
         default: return $urandom;
      endcase
   endfunction
   // Reference model: one operation in flight, product due LAT edges after its accept edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      started <= 1'b1;
      if (rst) begin
         m_act <= 0; m_rv <= 0; m_rid <= 0; m_rp <= '0; m_last <= 1; m_x <= '0; m_y <= '0; m_id <= 0;
      end else if (m_rv) begin
         if (bus.resp_ready) begin m_rv <= 0; m_act <= 0; end
      end else if (m_act) begin
         if (cyc == m_t + LAT) begin m_rv <= 1; m_rp <= prod(m_x, m_y); m_rid <= m_id; end
      end else if (bus.req0_valid || bus.req1_valid) begin
         m_act <= 1;
         m_t <= cyc;
         m_id <= win(bus.req0_valid, bus.req1_valid, m_last);
         m_last <= win(bus.req0_valid, bus.req1_valid, m_last);
         m_x <= win(bus.req0_valid, bus.req1_valid, m_last) ? bus.req1_a : bus.req0_a;
         m_y <= win(bus.req0_valid, bus.req1_valid, m_last) ? bus.req1_b : bus.req0_b;
      end
   end
   always @(negedge clk) if (started) begin
      check("req0_ready", bus.req0_ready, exp_ready(0));
      check("req1_ready", bus.req1_ready, exp_ready(1));
      check("busy", bus.busy, m_act);
      check("resp_valid", bus.resp_valid, m_rv);
      check("resp_p", bus.resp_p, m_rp);
      check("resp_id", bus.resp_id, m_rid);
      check("mul_x", bus.mul_x, m_x);
      check("mul_y", bus.mul_y, m_y);
      if (!rst && bus.req0_valid && bus.req0_ready) grant_q.push_back(0);
      if (!rst && bus.req1_valid && bus.req1_ready) grant_q.push_back(1);
      if (!rst && bus.resp_valid && bus.resp_ready) begin
         rp_q.push_back(bus.resp_p);
         rid_q.push_back(bus.resp_id);
      end
      if (rst) pend <= 0;
      else if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
         pend <= 1;
         acc_cyc <= cyc;
      end else if (pend && bus.resp_valid) begin
         pend <= 0;
         last_lat <= cyc - acc_cyc;
      end
   end
   task automatic issue(bit n, logic [31:0] a, logic [31:0] b);
      bit ok = 0;
      if (n) begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1; end
      else begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1; end
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = n ? bus.req1_ready : bus.req0_ready;
      end
      tick(1);
      if (n) bus.req1_valid = 0;
      else bus.req0_valid = 0;
      check("issue_accepted", 64'(ok), 64'd1);
   endtask
   initial begin
      int g0;
      int n;
      bit acc0, acc1, ok;
      bus.req0_valid = 0; bus.req1_valid = 0; bus.resp_ready = 0;
      bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
      bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.resp_ready = 0;
      bus1.req0_a = 0; bus1.req0_b = 0; bus1.req1_a = 0; bus1.req1_b = 0;
      tick(3);
      rst = 0;
      check("reset_busy", bus.busy, 0);
      check("reset_resp_valid", bus.resp_valid, 0);
      check("reset_mul_x", bus.mul_x, 0);
      // single request, -21
      bus.resp_ready = 1;
      issue(0, 32'd7, 32'hFFFFFFFD);
      check("t1_mul_x", bus.mul_x, 64'd7);
      check("t1_mul_y", bus.mul_y, 64'hFFFFFFFD);
      tick(6);
      check("t1_latency", last_lat, 3);
      check("t1_p", rp_q[$], 64'hFFFFFFFFFFFFFFEB);
      check("t1_id", rid_q[$], 0);
      // corner operands
      issue(1, 32'h80000000, 32'h80000000);
      tick(6);
      check("t2_p_minmin", rp_q[$], 64'h4000000000000000);
      check("t2_id", rid_q[$], 1);
      issue(1, 32'h7FFFFFFF, 32'h80000000);
      tick(6);
      check("t2_p_maxmin", rp_q[$], 64'hC000000080000000);
      // contention straight after reset
      rst = 1;
      tick(1);
      rst = 0;
      g0 = grant_q.size();
      n = rp_q.size();
      bus.req0_a = 32'd11; bus.req0_b = 32'hFFFFFFFE;
      bus.req1_a = 32'd1000; bus.req1_b = 32'd3;
      bus.req0_valid = 1; bus.req1_valid = 1;
      for (int i = 0; i < 100 && grant_q.size() < g0 + 4; i++) begin
         @(negedge clk);
         acc0 = bus.req0_ready;
         acc1 = bus.req1_ready;
         tick(1);
         if (acc0) begin bus.req0_a = bus.req0_a + 1; bus.req0_b = bus.req0_b - 5; end
         if (acc1) begin bus.req1_a = bus.req1_a * 3; bus.req1_b = bus.req1_b + 7; end
      end
      bus.req0_valid = 0; bus.req1_valid = 0;
      tick(6);
      for (int i = 0; i < 4; i++) begin
         check("t3_grant_order", (grant_q.size() > g0 + i) ? 64'(grant_q[g0 + i]) : 64'd9, 64'(i % 2));
         check("t3_resp_id", (rid_q.size() > n + i) ? 64'(rid_q[n + i]) : 64'd9, 64'(i % 2));
      end
      check("t3_first_p", rp_q[n], 64'hFFFFFFFFFFFFFFEA);
      // backpressure in DONE
      bus.resp_ready = 0;
      issue(0, 32'h12345678, 32'd9);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = bus.resp_valid;
         if (!ok) tick(1);
      end
      check("t4_done_reached", 64'(ok), 64'd1);
      bus.req0_valid = 1; bus.req1_valid = 1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("t4_hold_valid", bus.resp_valid, 1);
         check("t4_hold_p", bus.resp_p, 64'h00000000A3D70A38);
         check("t4_hold_ready", {bus.req0_ready, bus.req1_ready}, 0);
         check("t4_hold_busy", bus.busy, 1);
      end
      bus.req0_valid = 0; bus.req1_valid = 0; bus.resp_ready = 1;
      tick(1);
      check("t4_release_busy", bus.busy, 0);
      check("t4_release_valid", bus.resp_valid, 0);
      // reset in the second WAIT cycle discards the operation
      n = rp_q.size();
      issue(0, 32'd100, 32'd200);
      tick(1);
      rst = 1;
      tick(1);
      rst = 0;
      check("t5_busy", bus.busy, 0);
      check("t5_resp_valid", bus.resp_valid, 0);
      check("t5_mul_xy", {bus.mul_x, bus.mul_y}, 0);
      tick(5);
      check("t5_no_resp", rp_q.size(), n);
      issue(1, 32'd3, 32'd5);
      tick(6);
      check("t5_p", rp_q[$], 64'd15);
      // randomized traffic with backpressure and stray resets
      for (int i = 0; i < 3000; i++) begin
         bus.req0_valid = $urandom_range(0, 2) != 0;
         bus.req1_valid = $urandom_range(0, 2) != 0;
         bus.req0_a = pick(); bus.req0_b = pick();
         bus.req1_a = pick(); bus.req1_b = pick();
         bus.resp_ready = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 199) == 0;
         tick(1);
      end
      rst = 0; bus.req0_valid = 0; bus.req1_valid = 0; bus.resp_ready = 1;
      tick(5);
      // MUL_LAT=1 instance: -1 * -1
      bus1.resp_ready = 1;
      bus1.req0_a = 32'hFFFFFFFF; bus1.req0_b = 32'hFFFFFFFF; bus1.req0_valid = 1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = bus1.req0_ready;
      end
      tick(1);
      bus1.req0_valid = 0;
      check("l1_accepted", 64'(ok), 64'd1);
      check("l1_busy", bus1.busy, 1);
      check("l1_not_yet", bus1.resp_valid, 0);
      tick(1);
      check("l1_valid", bus1.resp_valid, 1);
      check("l1_p", bus1.resp_p, 64'd1);
      check("l1_id", bus1.resp_id, 0);
      tick(2);
      check("l1_idle", bus1.busy, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
Shares one combinational 32x32 signed radix-4 Booth multiplier (the partial-product block plus adder tree) between two requesters, e.g. the FP mantissa path and an integer path. The block runs a round-robin arbiter and a valid/ready handshake on each side. It holds the selected operands stable for a multicycle window of MUL_LAT cycles, then captures the 64-bit product and returns it with the requester ID. The multiplier instance sits outside this block and connects through the mul_* ports.

Parameters:
MUL_LAT, 2, cycles the operands are held stable before the product is sampled (multicycle path through the multiplier); legal 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  32  requester 0 multiplicand, two's complement
req0_b  input  32  requester 0 multiplier, two's complement
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  32  requester 1 multiplicand
req1_b  input  32  requester 1 multiplier
resp_valid  output  1  product available
resp_ready  input  1  consumer takes the product
resp_id  output  1  requester that issued the product
resp_p  output  64  signed product
mul_x  output  32  operand X to the multiplier
mul_y  output  32  operand Y to the multiplier
mul_p  input  64  product from the multiplier
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on the clk rising edge.
- FSM states: IDLE, WAIT, DONE.
- Reset values: state=IDLE, last_grant=1 (requester 0 wins the first tie), op_a=op_b=0, cnt=0, resp_p=0, resp_id=0, resp_valid=0, busy=0.
- mul_x and mul_y are driven directly from the op_a and op_b registers. They are 0 after reset and never change outside an accept edge.
- Arbitration is combinational and applies in IDLE only:
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester that is not last_grant.
- reqN_ready = (state==IDLE) && grant==N. At most one ready is high in any cycle. Both readys are 0 in WAIT and DONE.
- Accept edge (IDLE with reqN_valid && reqN_ready):
  - op_a<=reqN_a, op_b<=reqN_b, id<=N, last_grant<=N.
  - cnt<=MUL_LAT-1, state<=WAIT.
- WAIT:
  - cnt!=0: cnt decrements.
  - cnt==0: resp_p<=mul_p, resp_id<=id, resp_valid<=1, state<=DONE.
  - WAIT therefore lasts exactly MUL_LAT cycles. resp_valid first reads 1 after MUL_LAT+1 edges, counting the accept edge.
- DONE:
  - resp_valid, resp_p and resp_id stay stable until resp_ready is high.
  - On resp_valid && resp_ready: resp_valid<=0, state<=IDLE.
  - No new accept occurs in the same cycle as the response handshake. The next accept is possible in the following IDLE cycle.
  - Minimum occupancy per operation is MUL_LAT+2 cycles.
- Arithmetic: the block passes mul_p through unmodified. Signedness belongs to the multiplier. No width extension or truncation.
- Requester rule: reqN_a, reqN_b and reqN_valid must stay stable while valid is high and ready is low. The block does not check this. Dropping valid before ready is legal, and the request is simply not taken.
- resp_ready high while resp_valid is low is ignored.
- Synchronous reset in any state (including mid-WAIT and DONE) returns to the reset values on that edge:
  - an in-flight operation is discarded and no response is produced;
  - ready is 0 during the reset cycle.
- Starvation bound: under continuous contention the requests alternate 0,1,0,1. No requester waits more than one full operation.

Test Plan:
- Single request, MUL_LAT=2: req0 a=7, b=0xFFFFFFFD (−3) → req0_ready in the first IDLE cycle; mul_x=7 and mul_y=0xFFFFFFFD held for 2 cycles; resp_valid 3 edges after accept; resp_p=0xFFFFFFFFFFFFFFEB, resp_id=0.
- Corner operands: req1 a=b=0x80000000 → resp_p=0x4000000000000000, resp_id=1. Then a=0x7FFFFFFF, b=0x80000000 → resp_p=0xC000000080000000.
- Contention after reset: both valid continuously for 4 operations → grants in order 0,1,0,1. Each response carries the matching id and product. The readys are never high together.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_valid, resp_p and resp_id stay stable; both readys stay 0; busy=1. Releasing resp_ready returns the block to IDLE on that edge.
- Reset mid-WAIT: assert rst during the second WAIT cycle → next cycle state=IDLE, resp_valid=0, mul_x=mul_y=0, and no response appears. A fresh req1 with a=3, b=5 then gives resp_p=15.
- MUL_LAT=1 build: req0 a=−1, b=−1 → resp_valid 2 edges after accept, resp_p=1.
